// File: rtl/mux_n_1_arb_pkg.sv
// rtl/mux_n_1_arb_pkg.sv - shared constants and helpers for arbitrated bus muxes
//
// Purpose: the channel-index width function and the arbitration mode
// encodings. Other arbitrated muxes import these so that the meaning of
// `mode` stays the same everywhere.
package mux_n_1_arb_pkg;

  localparam logic MODE_RR    = 1'b0;  // round-robin, search starts after ptr
  localparam logic MODE_FIXED = 1'b1;  // fixed priority, lowest index wins

  // Smallest r with 2**r >= n. Result is at least 1 for n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_1_arb_rr_arbiter.sv
// rtl/mux_n_1_arb_rr_arbiter.sv - combinational round-robin / fixed-priority arbiter
//
// Purpose: picks one requesting channel.
// Ports:
//   req       in  channels  per-channel request
//   ptr       in  sel_w     index of the last winner (round-robin base)
//   mode      in  1         MODE_RR or MODE_FIXED
//   grant     out channels  one-hot grant, zero when nothing requests
//   grant_idx out sel_w     encoded grant (0 when nothing requests)
module rr_arbiter
  import mux_n_1_arb_pkg::*;
#(
  parameter int channels = 4,
  parameter int sel_w    = clog2(channels)
) (
  input  logic [channels-1:0] req,
  input  logic [sel_w-1:0]    ptr,
  input  logic                mode,
  output logic [channels-1:0] grant,
  output logic [sel_w-1:0]    grant_idx
);

  logic [2*channels-1:0] dbl;
  logic [2*channels-1:0] shifted;
  logic [channels-1:0]   rot;
  int                    start;
  int                    off;
  int                    idx;

  // Requests are duplicated side by side so that a right shift by the start
  // index behaves as a rotation; the lowest set bit of the rotated window is
  // then the first requester at or after the start position.
  always_comb begin
    dbl       = {req, req};
    start     = 0;
    off       = 0;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;

    if (mode == MODE_RR && int'(ptr) < channels - 1) begin
      start = int'(ptr) + 1;
    end

    shifted = dbl >> start;
    rot     = shifted[channels-1:0];

    for (int i = channels - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end
    end

    idx = start + off;
    if (idx >= channels) begin
      idx = idx - channels;
    end

    if (|rot) begin
      grant[idx] = 1'b1;
      grant_idx  = sel_w'(idx);
    end
  end

endmodule

// File: rtl/mux_n_1_arb.sv
// rtl/mux_n_1_arb.sv - registered N:1 bus mux with built-in arbitration
//
// Purpose: arbitrates between `channels` valid/ready sources and holds the
// winning word in a single output register for one downstream port.
// Ports:
//   clk        in  1                  clock, rising edge
//   rst_n      in  1                  synchronous active-low reset
//   in_data    in  channels*bus_size  channel i at [i*bus_size +: bus_size]
//   in_valid   in  channels           per-channel request
//   in_ready   out channels           per-channel accept (one-hot or zero)
//   mode       in  1                  MODE_RR / MODE_FIXED
//   out_data   out bus_size           registered selected word
//   out_sel    out sel_w              channel that supplied out_data
//   out_valid  out 1                  output register holds a word
//   out_ready  in  1                  downstream consumes out_data
module mux_n_1_arb
  import mux_n_1_arb_pkg::*;
#(
  parameter int bus_size = 32,
  parameter int channels = 4,
  parameter int sel_w    = clog2(channels)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [channels*bus_size-1:0] in_data,
  input  logic [channels-1:0]          in_valid,
  output logic [channels-1:0]          in_ready,
  input  logic                         mode,
  output logic [bus_size-1:0]          out_data,
  output logic [sel_w-1:0]             out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [sel_w-1:0]    ptr;
  logic [channels-1:0] grant;
  logic [sel_w-1:0]    grant_idx;
  logic                load;
  logic                take;
  logic [bus_size-1:0] sel_data;

  rr_arbiter #(
    .channels (channels),
    .sel_w    (sel_w)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The register can take a new word when it is empty or being drained
  // on this same edge, which gives full throughput without a skid buffer.
  assign load = !out_valid | out_ready;

  // rst_n gates in_ready so no source believes a word was taken during reset.
  assign in_ready = (rst_n && load) ? grant : '0;

  // grant only ever covers requesting channels, so any grant bit with load
  // set is an accepted transfer.
  assign take = load & (|grant);

  // One-hot AND-OR select keeps in_data off any priority-encoder path.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < channels; i++) begin
      sel_data = sel_data | (in_data[i*bus_size +: bus_size] & {bus_size{grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= sel_w'(channels - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      ptr       <= grant_idx;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule
